// File: rtl/flappy_pipe_ctrl_if.sv
// Bird/pipe game signals shared by the pipe controller, the bird FSM and the renderer.
// master drives bird position and game control; slave returns the obstacle, the score and the state.
interface flappy_pipe_ctrl_if;
  logic       Start;
  logic       Ack;
  logic       FrameTick;
  logic [9:0] XBird;
  logic [9:0] YBird;
  logic [9:0] PipeX;
  logic [9:0] GapY;
  logic [7:0] Score;
  logic       Collide;
  logic       q_Idle;
  logic       q_Run;
  logic       q_Hit;

  modport master (
    output Start, Ack, FrameTick, XBird, YBird,
    input  PipeX, GapY, Score, Collide, q_Idle, q_Run, q_Hit
  );

  modport slave (
    input  Start, Ack, FrameTick, XBird, YBird,
    output PipeX, GapY, Score, Collide, q_Idle, q_Run, q_Hit
  );
endinterface

// File: rtl/flappy_pipe_ctrl.sv
// Pipe obstacle, score and collision controller; advances once per FrameTick.
// Every update is visible one Clk after the sampling edge; there is no backpressure.
module flappy_pipe_ctrl #(
  parameter int         SCREEN_W  = 640,
  parameter int         SCREEN_H  = 480,
  parameter int         PIPE_W    = 40,
  parameter int         GAP_H     = 120,
  parameter int         GAP_MIN   = 40,
  parameter int         BIRD_SZ   = 16,
  parameter int         SPEED     = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic                Clk,
  input logic                Reset,
  flappy_pipe_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    HIT  = 3'b100
  } state_t;

  localparam logic [10:0] SW    = 11'(SCREEN_W);
  localparam logic [10:0] SH    = 11'(SCREEN_H);
  localparam logic [10:0] PW    = 11'(PIPE_W);
  localparam logic [10:0] GH    = 11'(GAP_H);
  localparam logic [10:0] GMIN  = 11'(GAP_MIN);
  localparam logic [10:0] BSZ   = 11'(BIRD_SZ);
  localparam logic [10:0] SPD   = 11'(SPEED);
  localparam logic [9:0]  GAP_RST = 10'(GMIN + {3'b000, LFSR_SEED});

  state_t     state_q;
  logic [9:0] pipe_x_q, gap_y_q;
  logic [7:0] score_q, lfsr_q;
  logic       collide_q, passed_q;

  logic [10:0] x_e, y_e, px_e, gy_e;
  logic        floor_hit, hov, vout, hit, wrap, score_now;
  logic [7:0]  lfsr_d, score_d;
  logic [9:0]  gap_y_d, pipe_x_d;

  // All geometry is done in 11 bits so sums of 10-bit positions never wrap.
  always_comb begin
    x_e       = {1'b0, bus.XBird};
    y_e       = {1'b0, bus.YBird};
    px_e      = {1'b0, pipe_x_q};
    gy_e      = {1'b0, gap_y_q};
    floor_hit = (y_e + BSZ) >= SH;
    hov       = ((x_e + BSZ) > px_e) && (x_e < (px_e + PW));
    vout      = (y_e < gy_e) || ((y_e + BSZ) > (gy_e + GH));
    hit       = floor_hit || (hov && vout);
    wrap      = px_e < SPD;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    gap_y_d   = 10'(GMIN + {3'b000, lfsr_d});
    pipe_x_d  = 10'(px_e - SPD);
    score_now = !passed_q && ((px_e + PW) < x_e);
    score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pipe_x_q  <= SW[9:0];
      gap_y_q   <= GAP_RST;
      score_q   <= 8'd0;
      collide_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      passed_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            state_q  <= RUN;
            pipe_x_q <= SW[9:0];
            score_q  <= 8'd0;
            passed_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.FrameTick) begin
            if (hit) begin
              state_q   <= HIT;
              collide_q <= 1'b1;
            end else if (wrap) begin
              pipe_x_q <= SW[9:0];
              lfsr_q   <= lfsr_d;
              gap_y_q  <= gap_y_d;
              passed_q <= 1'b0;
            end else begin
              pipe_x_q <= pipe_x_d;
              // Score once per pipe, when its trailing edge clears the bird.
              if (score_now) begin
                score_q  <= score_d;
                passed_q <= 1'b1;
              end
            end
          end
        end
        HIT: begin
          if (bus.Ack) begin
            state_q   <= IDLE;
            collide_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          collide_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PipeX   = pipe_x_q;
  assign bus.GapY    = gap_y_q;
  assign bus.Score   = score_q;
  assign bus.Collide = collide_q;
  assign bus.q_Idle  = state_q[0];
  assign bus.q_Run   = state_q[1];
  assign bus.q_Hit   = state_q[2];

endmodule

// File: tb/tb_flappy_pipe_ctrl.sv
// Directed bench for flappy_pipe_ctrl: reset, motion, wrap/LFSR, scoring, hits, floor and async reset.
module tb_flappy_pipe_ctrl;
  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  flappy_pipe_ctrl_if bus ();
  flappy_pipe_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk) bus.FrameTick = 1'b1;
      @(negedge Clk) bus.FrameTick = 1'b0;
    end
  endtask

  task automatic start_game();
    @(negedge Clk) bus.Start = 1'b1;
    @(negedge Clk) bus.Start = 1'b0;
  endtask

  task automatic ack_loss();
    @(negedge Clk) bus.Ack = 1'b1;
    @(negedge Clk) bus.Ack = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.q_Idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %0b want 1", bus.q_Idle); end
    checks++; if (bus.q_Run !== 1'b0) begin errors++; $display("FAIL rst_run got %0b want 0", bus.q_Run); end
    checks++; if (bus.PipeX !== 10'd640) begin errors++; $display("FAIL rst_pipex got %0d want 640", bus.PipeX); end
    checks++; if (bus.GapY !== 10'd205) begin errors++; $display("FAIL rst_gapy got %0d want 205", bus.GapY); end
    checks++; if (bus.Score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d want 0", bus.Score); end
    checks++; if (bus.Collide !== 1'b0) begin errors++; $display("FAIL rst_collide got %0b want 0", bus.Collide); end
    bus.XBird = 10'd100; bus.YBird = 10'd210;
    tick(3);
    checks++; if (bus.PipeX !== 10'd640 || bus.q_Idle !== 1'b1) begin errors++; $display("FAIL idle_tick pipex %0d idle %0b want 640 1", bus.PipeX, bus.q_Idle); end
    start_game();
    tick(10);
    checks++; if (bus.PipeX !== 10'd620) begin errors++; $display("FAIL run10_pipex got %0d want 620", bus.PipeX); end
    checks++; if (bus.q_Run !== 1'b1) begin errors++; $display("FAIL run10_state got %0b want 1", bus.q_Run); end
  endtask

  task automatic test_wrap_and_score();
    do_reset();
    bus.XBird = 10'd100; bus.YBird = 10'd210;
    start_game();
    tick(291);
    checks++; if (bus.PipeX !== 10'd58 || bus.Score !== 8'd0) begin errors++; $display("FAIL pre_score pipex %0d score %0d want 58 0", bus.PipeX, bus.Score); end
    tick(1);
    checks++; if (bus.PipeX !== 10'd56 || bus.Score !== 8'd1) begin errors++; $display("FAIL first_score pipex %0d score %0d want 56 1", bus.PipeX, bus.Score); end
    tick(28);
    checks++; if (bus.PipeX !== 10'd0 || bus.Score !== 8'd1) begin errors++; $display("FAIL at_zero pipex %0d score %0d want 0 1", bus.PipeX, bus.Score); end
    tick(1);
    checks++; if (bus.PipeX !== 10'd640) begin errors++; $display("FAIL wrap_pipex got %0d want 640", bus.PipeX); end
    checks++; if (dut.lfsr_q !== 8'h4A) begin errors++; $display("FAIL wrap_lfsr got %h want 4a", dut.lfsr_q); end
    checks++; if (bus.GapY !== 10'd114) begin errors++; $display("FAIL wrap_gapy got %0d want 114", bus.GapY); end
    tick(291);
    checks++; if (bus.Score !== 8'd1) begin errors++; $display("FAIL pipe2_pre got %0d want 1", bus.Score); end
    tick(1);
    checks++; if (bus.Score !== 8'd2 || bus.PipeX !== 10'd56) begin errors++; $display("FAIL pipe2_score score %0d pipex %0d want 2 56", bus.Score, bus.PipeX); end
    ack_loss();
    checks++; if (bus.q_Run !== 1'b1 || bus.PipeX !== 10'd56) begin errors++; $display("FAIL ack_in_run run %0b pipex %0d want 1 56", bus.q_Run, bus.PipeX); end
  endtask

  task automatic test_reset_mid_run();
    tick(29);
    checks++; if (bus.GapY !== 10'd189 || bus.Score !== 8'd2) begin errors++; $display("FAIL wrap2 gapy %0d score %0d want 189 2", bus.GapY, bus.Score); end
    tick(292 + 29 + 170);
    checks++; if (bus.PipeX !== 10'd300 || bus.Score !== 8'd3 || bus.GapY !== 10'd82) begin
      errors++; $display("FAIL mid_run pipex %0d score %0d gapy %0d want 300 3 82", bus.PipeX, bus.Score, bus.GapY);
    end
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++; if (bus.q_Idle !== 1'b1 || bus.q_Run !== 1'b0) begin errors++; $display("FAIL async_rst_state idle %0b run %0b want 1 0", bus.q_Idle, bus.q_Run); end
    checks++; if (bus.PipeX !== 10'd640 || bus.Score !== 8'd0 || bus.GapY !== 10'd205) begin
      errors++; $display("FAIL async_rst_vals pipex %0d score %0d gapy %0d want 640 0 205", bus.PipeX, bus.Score, bus.GapY);
    end
    @(negedge Clk) Reset = 1'b0;
  endtask

  task automatic test_hit();
    bus.XBird = 10'd100; bus.YBird = 10'd210;
    start_game();
    tick(270);
    checks++; if (bus.PipeX !== 10'd100 || bus.q_Run !== 1'b1) begin errors++; $display("FAIL hit_setup pipex %0d run %0b want 100 1", bus.PipeX, bus.q_Run); end
    bus.YBird = 10'd100;
    tick(1);
    checks++; if (bus.q_Hit !== 1'b1 || bus.Collide !== 1'b1) begin errors++; $display("FAIL hit_state hit %0b collide %0b want 1 1", bus.q_Hit, bus.Collide); end
    checks++; if (bus.PipeX !== 10'd100) begin errors++; $display("FAIL hit_pipex got %0d want 100", bus.PipeX); end
    bus.Start = 1'b1;
    tick(5);
    bus.Start = 1'b0;
    checks++; if (bus.q_Hit !== 1'b1 || bus.PipeX !== 10'd100 || bus.GapY !== 10'd205 || bus.Score !== 8'd0) begin
      errors++; $display("FAIL hit_hold hit %0b pipex %0d gapy %0d score %0d want 1 100 205 0", bus.q_Hit, bus.PipeX, bus.GapY, bus.Score);
    end
    ack_loss();
    checks++; if (bus.q_Idle !== 1'b1 || bus.Collide !== 1'b0) begin errors++; $display("FAIL hit_ack idle %0b collide %0b want 1 0", bus.q_Idle, bus.Collide); end
  endtask

  task automatic test_floor();
    bus.YBird = 10'd210;
    start_game();
    tick(20);
    checks++; if (bus.PipeX !== 10'd600) begin errors++; $display("FAIL floor_setup pipex got %0d want 600", bus.PipeX); end
    bus.YBird = 10'd464;
    tick(1);
    checks++; if (bus.q_Hit !== 1'b1 || bus.PipeX !== 10'd600) begin errors++; $display("FAIL floor_464 hit %0b pipex %0d want 1 600", bus.q_Hit, bus.PipeX); end
    ack_loss();
    bus.YBird = 10'd210;
    start_game();
    tick(20);
    bus.YBird = 10'd463;
    tick(1);
    checks++; if (bus.q_Run !== 1'b1 || bus.PipeX !== 10'd598) begin errors++; $display("FAIL floor_463 run %0b pipex %0d want 1 598", bus.q_Run, bus.PipeX); end
  endtask

  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.FrameTick = 1'b0;
    bus.XBird = 10'd0; bus.YBird = 10'd0;
    test_reset();
    test_wrap_and_score();
    test_reset_mid_run();
    test_hit();
    test_floor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
